// File: rtl/array_input_serializer.sv
// Bit-serial driver for the array wordlines: splits each signed lane into positive and
// negative magnitude rails and streams them MSB-first, with a one-entry holding register.
module array_input_serializer #(
    parameter int CHANNEL = 10,
    parameter int BITS    = 4,
    localparam int MAG    = BITS - 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CHANNEL*BITS-1:0] in_data,
    output logic [CHANNEL-1:0]      out_bit,
    output logic [CHANNEL-1:0]      out_bitb,
    output logic                    out_valid,
    output logic                    frame_start,
    output logic                    frame_end,
    output logic                    busy
);

    localparam int CNT_W = (MAG > 1) ? $clog2(MAG) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                    state_r;
    logic [CNT_W-1:0]          cnt_r;
    logic [CHANNEL*BITS-1:0]   hold_r;
    logic                      hold_full_r;
    logic [CHANNEL-1:0][MAG-1:0] pos_sr_r;
    logic [CHANNEL-1:0][MAG-1:0] neg_sr_r;
    logic [CHANNEL-1:0][MAG-1:0] hold_pos_s;
    logic [CHANNEL-1:0][MAG-1:0] hold_neg_s;
    logic                      accept_s;
    logic                      load_s;
    logic                      shift_nxt_s;
    logic                      hold_nxt_s;

    // Sign-magnitude split of one lane; the most negative code saturates to full scale.
    function automatic logic [2*MAG-1:0] to_rails(input logic [BITS-1:0] v);
        logic [BITS-1:0] nv;
        logic [MAG-1:0]  pos;
        logic [MAG-1:0]  neg;
        nv  = ~v + {{(BITS-1){1'b0}}, 1'b1};
        pos = {MAG{1'b0}};
        neg = {MAG{1'b0}};
        if (v[BITS-1] == 1'b0) begin
            pos = v[MAG-1:0];
        end else if (v[MAG-1:0] == {MAG{1'b0}}) begin
            neg = {MAG{1'b1}};
        end else begin
            neg = nv[MAG-1:0];
        end
        return {pos, neg};
    endfunction

    assign accept_s    = in_valid && in_ready;
    assign load_s      = hold_full_r && ((state_r == IDLE) || (cnt_r == {CNT_W{1'b0}}));
    assign shift_nxt_s = load_s || ((state_r == SHIFT) && (cnt_r != {CNT_W{1'b0}}));
    assign hold_nxt_s  = accept_s || (hold_full_r && !load_s);

    // Rail conversion of the holding register contents for the next load.
    always_comb begin
        hold_pos_s = {(CHANNEL*MAG){1'b0}};
        hold_neg_s = {(CHANNEL*MAG){1'b0}};
        for (int i = 0; i < CHANNEL; i++) begin
            {hold_pos_s[i], hold_neg_s[i]} = to_rails(hold_r[i*BITS +: BITS]);
        end
    end

    // Holding register, shift FSM and registered serial outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            hold_r      <= {(CHANNEL*BITS){1'b0}};
            hold_full_r <= 1'b0;
            pos_sr_r    <= {(CHANNEL*MAG){1'b0}};
            neg_sr_r    <= {(CHANNEL*MAG){1'b0}};
            out_bit     <= {CHANNEL{1'b0}};
            out_bitb    <= {CHANNEL{1'b0}};
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            busy        <= 1'b0;
            in_ready    <= 1'b1;
        end else begin
            if (accept_s) begin
                hold_r <= in_data;
            end
            hold_full_r <= hold_nxt_s;
            in_ready    <= !hold_nxt_s;
            busy        <= hold_nxt_s || shift_nxt_s;

            if (load_s) begin
                // The MSB goes straight to the outputs so a frame starts one edge after accept.
                state_r     <= SHIFT;
                cnt_r       <= CNT_W'(MAG - 1);
                out_valid   <= 1'b1;
                frame_start <= 1'b1;
                frame_end   <= (MAG == 1);
                for (int i = 0; i < CHANNEL; i++) begin
                    out_bit[i]  <= hold_pos_s[i][MAG-1];
                    out_bitb[i] <= hold_neg_s[i][MAG-1];
                    pos_sr_r[i] <= hold_pos_s[i] << 1'b1;
                    neg_sr_r[i] <= hold_neg_s[i] << 1'b1;
                end
            end else if ((state_r == SHIFT) && (cnt_r != {CNT_W{1'b0}})) begin
                state_r     <= SHIFT;
                cnt_r       <= cnt_r - CNT_W'(1);
                out_valid   <= 1'b1;
                frame_start <= 1'b0;
                frame_end   <= (cnt_r == CNT_W'(1));
                for (int i = 0; i < CHANNEL; i++) begin
                    out_bit[i]  <= pos_sr_r[i][MAG-1];
                    out_bitb[i] <= neg_sr_r[i][MAG-1];
                    pos_sr_r[i] <= pos_sr_r[i] << 1'b1;
                    neg_sr_r[i] <= neg_sr_r[i] << 1'b1;
                end
            end else begin
                state_r     <= IDLE;
                cnt_r       <= {CNT_W{1'b0}};
                out_valid   <= 1'b0;
                frame_start <= 1'b0;
                frame_end   <= 1'b0;
                out_bit     <= {CHANNEL{1'b0}};
                out_bitb    <= {CHANNEL{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_array_input_serializer.sv
// Directed bench for array_input_serializer (CHANNEL=10, BITS=4): framing, rail split,
// saturation, back-to-back streaming, mid-frame reset and a receive-side round trip.
module tb_array_input_serializer;

    localparam int CHANNEL = 10;
    localparam int BITS    = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [CHANNEL*BITS-1:0] in_data;
    logic [CHANNEL-1:0]      out_bit;
    logic [CHANNEL-1:0]      out_bitb;
    logic                    out_valid;
    logic                    frame_start;
    logic                    frame_end;
    logic                    busy;

    int checks = 0;
    int errors = 0;

    logic [2:0][9:0] pb;
    logic [2:0][9:0] nb;
    logic [39:0]     vec [3];
    logic [10:0]     e_val, e_fs, e_fe, e_rdy;
    logic [9:0]      e_ob [11];
    logic [9:0]      e_obb [11];
    logic            rdy_prev, acc;
    int              nacc;
    int              lv [10];
    logic [39:0]     d;
    int              p, n, r;

    always #5 clk = ~clk;

    array_input_serializer #(.CHANNEL(CHANNEL), .BITS(BITS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_bit(out_bit), .out_bitb(out_bitb), .out_valid(out_valid),
        .frame_start(frame_start), .frame_end(frame_end), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one vector into an idle block and record the three streamed bit slices.
    task automatic capture_frame(input string tag, input logic [39:0] data,
                                 output logic [2:0][9:0] cpb, output logic [2:0][9:0] cnb);
        check({tag, "_rdy0"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = data;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 40'hFF_FFFF_FFFF;
        check({tag, "_wait_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_wait_busy"}, 32'(busy), 32'd1);
        check({tag, "_wait_rdy"}, 32'(in_ready), 32'd0);
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            check($sformatf("%s_valid_b%0d", tag, b), 32'(out_valid), 32'd1);
            check($sformatf("%s_fs_b%0d", tag, b), 32'(frame_start), 32'(b == 0));
            check($sformatf("%s_fe_b%0d", tag, b), 32'(frame_end), 32'(b == 2));
            cpb[b] = out_bit;
            cnb[b] = out_bitb;
        end
        @(negedge clk);
        check({tag, "_end_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_end_bits"}, 32'({out_bit, out_bitb}), 32'd0);
        check({tag, "_end_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // 1: reset
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 40'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_bits", 32'({out_bit, out_bitb}), 32'd0);
        check("rst_flags", 32'({out_valid, frame_start, frame_end, busy}), 32'd0);
        check("rst_rdy", 32'(in_ready), 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("postrst_flags", 32'({out_valid, frame_start, frame_end, busy}), 32'd0);
        check("postrst_rdy", 32'(in_ready), 32'd1);

        // 2: single frame, lane0=+5, lane1=-3
        capture_frame("t2", 40'h00_0000_00D5, pb, nb);
        check("t2_pos", 32'(pb), 32'({10'h001, 10'h000, 10'h001}));
        check("t2_neg", 32'(nb), 32'({10'h002, 10'h002, 10'h000}));

        // 3: lane2=-8 saturates, lane3=+7, lane4=0
        capture_frame("t3", 40'h00_0000_7800, pb, nb);
        check("t3_pos", 32'(pb), 32'({10'h008, 10'h008, 10'h008}));
        check("t3_neg", 32'(nb), 32'({10'h004, 10'h004, 10'h004}));

        // 4: three vectors back-to-back: A lane0=+1, B lane5=-5, C lane9=+6
        vec[0] = 40'h00_0000_0001;
        vec[1] = 40'h00_00B0_0000;
        vec[2] = 40'h60_0000_0000;
        e_val  = 11'b01111111110;
        e_fs   = 11'b00010010010;
        e_fe   = 11'b01001001000;
        e_rdy  = 11'b11110010010;
        for (int k = 0; k < 11; k++) begin
            e_ob[k]  = 10'h000;
            e_obb[k] = 10'h000;
        end
        e_ob[3]  = 10'h001;
        e_ob[7]  = 10'h200;
        e_ob[8]  = 10'h200;
        e_obb[4] = 10'h020;
        e_obb[6] = 10'h020;
        nacc     = 0;
        rdy_prev = in_ready;
        in_valid = 1'b1;
        in_data  = vec[0];
        for (int k = 0; k < 11; k++) begin
            @(posedge clk);
            acc = in_valid && rdy_prev;
            @(negedge clk);
            if (acc) begin
                nacc++;
                if (nacc < 3) in_data = vec[nacc];
                else in_valid = 1'b0;
            end
            check($sformatf("t4_valid_k%0d", k), 32'(out_valid), 32'(e_val[k]));
            check($sformatf("t4_fs_k%0d", k), 32'(frame_start), 32'(e_fs[k]));
            check($sformatf("t4_fe_k%0d", k), 32'(frame_end), 32'(e_fe[k]));
            check($sformatf("t4_rdy_k%0d", k), 32'(in_ready), 32'(e_rdy[k]));
            check($sformatf("t4_pos_k%0d", k), 32'(out_bit), 32'(e_ob[k]));
            check($sformatf("t4_neg_k%0d", k), 32'(out_bitb), 32'(e_obb[k]));
            rdy_prev = in_ready;
        end
        check("t4_accepts", 32'(nacc), 32'd3);
        check("t4_idle_busy", 32'(busy), 32'd0);

        // 5: reset pulsed during bit 2 of lane0=+7, then a fresh frame lane1=+6
        in_valid = 1'b1;
        in_data  = 40'h00_0000_0007;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("t5_b1", 32'({out_valid, frame_start, out_bit}), 32'({1'b1, 1'b1, 10'h001}));
        @(negedge clk);
        check("t5_b2", 32'({out_valid, frame_start, out_bit}), 32'({1'b1, 1'b0, 10'h001}));
        rst = 1'b1;
        #1;
        check("t5_rst_bits", 32'({out_bit, out_bitb}), 32'd0);
        check("t5_rst_flags", 32'({out_valid, frame_start, frame_end, busy}), 32'd0);
        check("t5_rst_rdy", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5_after_valid", 32'(out_valid), 32'd0);
        capture_frame("t5", 40'h00_0000_0060, pb, nb);
        check("t5_pos", 32'(pb), 32'({10'h000, 10'h002, 10'h002}));
        check("t5_neg", 32'(nb), 32'd0);

        // 6: round trip through a shift-add / subtract / relu receive model
        for (int f = 0; f < 4; f++) begin
            d = 40'h0;
            for (int i = 0; i < CHANNEL; i++) begin
                lv[i] = int'($urandom_range(0, 7));
                d[i*BITS +: BITS] = lv[i][3:0];
            end
            capture_frame($sformatf("t6f%0d", f), d, pb, nb);
            for (int i = 0; i < CHANNEL; i++) begin
                p = 0;
                n = 0;
                for (int b = 0; b < 3; b++) begin
                    p = p * 2 + int'(pb[b][i]);
                    n = n * 2 + int'(nb[b][i]);
                end
                r = (p - n > 0) ? (p - n) : 0;
                check($sformatf("t6f%0d_lane%0d", f, i), 32'(r), 32'(lv[i]));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
